fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction-fetch stage for the five-stage MIPS pipeline: owns the PC register, drives the instruction-memory address, and buffers fetched {PC, instruction} pairs in a DEPTH-entry FIFO ahead of decode. Decode consumes entries through a valid/ready handshake instead of a global enable. A redirect port, used for branches, jumps and exceptions, flushes the queue and reloads the PC. It decouples fetch from decode stalls and supersedes the single-register PC/mux fetch path.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- RESET_PC, 32'h0000_3000: PC value loaded on reset
- IMEM_BASE, 32'h0000_3000: lowest legal fetch address (used only with FETCH_EXC_EN)
- IMEM_SIZE, 32'h0000_1000: legal fetch window size in bytes (used only with FETCH_EXC_EN)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_addr  out  32  fetch address, equals current PC
- imem_rdata  in  32  instruction word; combinational, valid in the same cycle as imem_addr
- redirect  in  1  flush and reload PC this cycle
- redirect_pc  in  32  new PC when redirect=1
- out_valid  out  1  head entry present
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_exc  out  1  head entry is a fetch fault (only with FETCH_EXC_EN)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer with rd_ptr, wr_ptr and count. Outputs come directly from the head entry. When count=0, out_instr and out_pc are don't-care.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & ~halted & (count<DEPTH | pop). Push writes {pc, imem_rdata} at wr_ptr, then pc <= pc+4.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000. Low bits are not masked.
- Simultaneous push and pop: count is unchanged. This is legal when full, because the popped slot is reused in the same edge.
- redirect=1 has priority over everything:
  - count <= 0 and both pointers <= 0.
  - pc <= redirect_pc and halted <= 0.
  - No push and no pop occur that cycle, even if out_ready=1.
- Pointers wrap modulo DEPTH.
- State: `halted` is 1 bit, set only under FETCH_EXC_EN. Without the macro it is tied to 0.

## Timing
- Reset values:
  - pc = RESET_PC
  - count = 0, rd_ptr = 0, wr_ptr = 0
  - out_valid = 0, out_exc = 0, halted = 0
  - imem_addr = RESET_PC
- Fetch-to-decode latency is 1 cycle. A word pushed at edge N is visible as the head at edge N if the queue was empty, so out_valid rises in cycle N+1.
- First cycle after reset is released: imem_addr = RESET_PC. The next cycle presents out_valid=1 and out_pc=RESET_PC.
- Redirect at edge N: out_valid=0 in cycle N+1, and imem_addr=redirect_pc in cycle N+1. The first redirected entry is valid in cycle N+2.
- Reset asserted mid-operation: all state returns to reset values at the next edge. Queued entries are discarded.
- Sustained throughput is one instruction per cycle when out_ready is held at 1.

## Configuration
- FETCH_EXC_EN defined: each fetch is checked before push.
  - The fetch faults if pc[1:0]!=0, or if pc is outside [IMEM_BASE, IMEM_BASE+IMEM_SIZE).
  - A faulting fetch pushes an entry with exc=1, instr=32'h0000_0000 (nop) and its pc.
  - The fetch then sets halted=1. No further pushes occur until a redirect.
  - out_exc reflects the head entry's exc bit.
- FETCH_EXC_EN undefined:
  - No check is performed, and no out_exc port or exc storage exists.
  - Any pc is fetched as is.

## Test plan
- Reset release with out_ready=1 and IMEM returning addr-derived words: out_pc streams 0x3000, 0x3004, 0x3008…, one per cycle, count stays 1.
- out_ready=0 for 10 cycles: count saturates at DEPTH=4 with entries 0x3000..0x300C. imem_addr then holds at 0x3010. Releasing out_ready yields 0x3000 next, with no loss or duplication.
- Full queue with out_ready=1: simultaneous push and pop each cycle, count stays 4, and the PC sequence is contiguous.
- redirect=1 with redirect_pc=0x3400 while count=3 and out_ready=1: no pop, count=0 next cycle, then out_pc=0x3400 and 0x3404.
- Reset mid-stream with count=2: next cycle count=0 and imem_addr=0x3000.
- FETCH_EXC_EN with redirect_pc=0x3002: one entry with out_exc=1 and out_instr=0. No further entries follow until redirect to 0x3000, after which normal entries have exc=0. A fetch at 0x4000 likewise faults.

Source files
------------

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction-fetch stage. Owns the PC, drives the instruction
//            memory address, and buffers fetched {pc, instr} pairs in a
//            DEPTH-entry circular queue that decode drains via valid/ready.
//            A redirect flushes the queue and reloads the PC.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            imem_addr         - fetch address (current PC)
//            imem_rdata        - combinational instruction word for imem_addr
//            redirect/_pc      - flush queue and load new PC
//            out_valid/ready   - head-entry handshake towards decode
//            out_instr/out_pc  - head entry contents
//            out_exc           - head entry is a fetch fault (FETCH_EXC_EN)
//            count             - current queue occupancy
// Options  : `define FETCH_EXC_EN enables fetch-address checking, the
//            out_exc port and the halted state.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_1000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
`ifdef FETCH_EXC_EN
    output logic                     out_exc,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [31:0]        r_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [31:0]        r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];

    logic               w_halted;
    logic               w_pop;
    logic               w_push;
    logic [31:0]        w_push_instr;

    // A full queue may still accept a push when the head is popped on the
    // same edge: the freed slot is refilled immediately.
    assign w_pop  = (r_count != '0) & out_ready & ~redirect;
    assign w_push = ~redirect & ~w_halted &
                    ((r_count < c_CNT_W'(DEPTH)) | w_pop);

`ifdef FETCH_EXC_EN
    logic               r_halted;
    logic               r_exc_mem [DEPTH];
    logic [31:0]        w_offset;
    logic               w_fault;

    // Window test on the offset from the base avoids overflow of
    // IMEM_BASE + IMEM_SIZE near the top of the address space.
    assign w_offset     = r_pc - IMEM_BASE;
    assign w_fault      = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_BASE) |
                          (w_offset >= IMEM_SIZE);
    assign w_push_instr = w_fault ? 32'h0000_0000 : imem_rdata;
    assign w_halted     = r_halted;

    // After a faulting fetch the stream stops until software redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (redirect) begin
            r_halted <= 1'b0;
        end else if (w_push && w_fault) begin
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_exc_mem[r_wr_ptr] <= w_fault;
        end
    end

    assign out_exc = (r_count != '0) & r_exc_mem[r_rd_ptr];
`else
    logic w_unused_params;

    assign w_push_instr    = imem_rdata;
    assign w_halted        = 1'b0;
    assign w_unused_params = ^{IMEM_BASE, IMEM_SIZE};
`endif

    // Control state: PC, pointers and occupancy. Redirect outranks any
    // push/pop; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Queue storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_pc_mem[r_wr_ptr]    <= r_pc;
            r_instr_mem[r_wr_ptr] <= w_push_instr;
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = (r_count != '0);
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign out_pc    = r_pc_mem[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Self-checking bench for fetch_queue_unit. A queue-based
//            reference model tracks PC, entries and halted state; every
//            cycle the DUT outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
    localparam logic [31:0] IMEM_SIZE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_EXC_EN
    logic        out_exc;
`endif
    logic [$clog2(DEPTH):0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .IMEM_BASE (IMEM_BASE),
        .IMEM_SIZE (IMEM_SIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
`ifdef FETCH_EXC_EN
        .out_exc     (out_exc),
`endif
        .count       (count)
    );

    // Memory image: an address-derived word so every fetch is distinguishable.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    always_comb imem_rdata = instr_of(imem_addr);

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc     = RESET_PC;
    bit          m_halted = 1'b0;

    function automatic bit is_fault(input logic [31:0] a);
`ifdef FETCH_EXC_EN
        longint lo, hi, x;
        lo = longint'(IMEM_BASE);
        hi = lo + longint'(IMEM_SIZE);
        x  = longint'(a);
        return (a % 4 != 0) || (x < lo) || (x >= hi);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_edge(input bit rst, input bit rdy,
                                       input bit redir, input logic [31:0] rpc);
        bit   pop, push, f;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC;
            m_halted = 1'b0;
        end else if (redir) begin
            mq.delete();
            m_pc = rpc;
            m_halted = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            push = !m_halted && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                f = is_fault(m_pc);
                e.pc    = m_pc;
                e.instr = f ? 32'h0 : instr_of(m_pc);
                e.exc   = f;
                mq.push_back(e);
                if (f) m_halted = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("imem_addr", imem_addr, m_pc);
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
`ifdef FETCH_EXC_EN
            chk("out_exc", 32'(out_exc), 32'(mq[0].exc));
`endif
        end
`ifdef FETCH_EXC_EN
        else begin
            chk("out_exc_empty", 32'(out_exc), 32'd0);
        end
`endif
    endtask

    // Drive one cycle's inputs, advance the model across the edge, then check.
    task automatic step(input bit rst, input bit rdy, input bit redir,
                        input logic [31:0] rpc);
        reset       = rst;
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        model_edge(rst, rdy, redir, rpc);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] rpc;
        bit          rdy, redir, rst;

        // Reset and release with decode always ready: one-per-cycle stream.
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("reset_addr", imem_addr, 32'h0000_3000);
        chk("reset_valid", 32'(out_valid), 32'd0);
        step(0, 1, 0, 0);
        chk("first_pc", out_pc, 32'h0000_3000);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        chk("stream_count", 32'(count), 32'd1);

        // Decode stalled: queue fills with 0x3000..0x300C, fetch holds.
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_addr", imem_addr, 32'h0000_3010);
        chk("full_head", out_pc, 32'h0000_3000);
        // Release: simultaneous push/pop keeps the queue full.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        chk("steady_full", 32'(count), 32'd4);

        // Redirect while three entries are queued and decode is ready.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("pre_redir", 32'(count), 32'd3);
        step(0, 1, 1, 32'h0000_3400);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_addr", imem_addr, 32'h0000_3400);
        step(0, 1, 0, 0);
        chk("redir_pc0", out_pc, 32'h0000_3400);
        step(0, 1, 0, 0);
        chk("redir_pc1", out_pc, 32'h0000_3404);

        // Reset mid-stream with two entries queued.
        step(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("mid_reset_count", 32'(count), 32'd0);
        chk("mid_reset_addr", imem_addr, 32'h0000_3000);

`ifndef FETCH_EXC_EN
        // PC wraps modulo 2^32.
        step(0, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0000_0008);
`else
        // Misaligned fetch faults and halts the stream.
        step(0, 1, 1, 32'h0000_3002);
        step(0, 0, 0, 0);
        chk("mis_exc", 32'(out_exc), 32'd1);
        chk("mis_instr", out_instr, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("halted_count", 32'(count), 32'd1);
        step(0, 1, 1, 32'h0000_3000);
        step(0, 1, 0, 0);
        chk("recover_exc", 32'(out_exc), 32'd0);
        // Out-of-window fetch faults.
        step(0, 1, 1, 32'h0000_4000);
        step(0, 1, 0, 0);
        chk("oow_exc", 32'(out_exc), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("oow_halted", 32'(count), 32'd0);
        step(0, 1, 1, 32'h0000_3FF8);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0)
                rpc = $urandom;
            else
                rpc = 32'h0000_3000 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            step(rst, rdy, redir, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
